// File: rtl/placement_eval.sv
// Placement evaluator: walks an edge list, fetches both endpoint positions,
// accumulates wirelength costs and reports the first illegally placed edge.
module placement_eval #(
   parameter int N_EDGE    = 30,
   parameter int N         = 6,
   parameter int HOP_LIMIT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               re_ea,
   output logic               re_eb,
   output logic [31:0]        addr_ea,
   output logic [31:0]        addr_eb,
   input  logic [31:0]        dout_ea,
   input  logic [31:0]        dout_eb,
   output logic               re_px,
   output logic               re_py,
   output logic [31:0]        addr_px,
   output logic [31:0]        addr_py,
   input  logic signed [31:0] dout_px,
   input  logic signed [31:0] dout_py,
   output logic               busy,
   output logic               done,
   output logic               valid,
   output logic               err,
   output logic [31:0]        err_edge,
   output logic signed [31:0] sum,
   output logic signed [31:0] sum_1hop,
   output logic [31:0]        max_dist,
   output logic [31:0]        over_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH_E, S_WAIT_E, S_FETCH_A, S_WAIT_A,
      S_FETCH_B, S_WAIT_B, S_LATCH_B, S_ABS, S_ACC, S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [31:0]        i_q, i_d, b_q, b_d;
   logic signed [31:0] xa_q, xa_d, ya_q, ya_d;
   logic signed [31:0] xb_q, xb_d, yb_q, yb_d;
   logic signed [31:0] dx_q, dx_d, dy_q, dy_d, d_q, d_d;
   logic               re_e_q, re_e_d, re_p_q, re_p_d;
   logic [31:0]        addr_e_q, addr_e_d, addr_p_q, addr_p_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               valid_q, valid_d, err_q, err_d;
   logic [31:0]        err_edge_q, err_edge_d;
   logic signed [31:0] sum_q, sum_d, s1_q, s1_d;
   logic [31:0]        max_q, max_d, over_q, over_d;

   logic signed [31:0] ddx, ddy;
   logic [31:0]        hop;
   logic               off;

   function automatic logic out_of_grid(input logic signed [31:0] v);
      return (v < 0) || (v >= N);
   endfunction

   // Next-state and datapath updates for the per-edge fetch/accumulate walk
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      b_d        = b_q;
      xa_d       = xa_q;
      ya_d       = ya_q;
      xb_d       = xb_q;
      yb_d       = yb_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      d_d        = d_q;
      re_e_d     = 1'b0;
      re_p_d     = 1'b0;
      addr_e_d   = addr_e_q;
      addr_p_d   = addr_p_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      valid_d    = valid_q;
      err_d      = err_q;
      err_edge_d = err_edge_q;
      sum_d      = sum_q;
      s1_d       = s1_q;
      max_d      = max_q;
      over_d     = over_q;
      ddx        = xa_q - xb_q;
      ddy        = ya_q - yb_q;
      hop        = (dx_q >> 1) + 32'(dx_q[0])
                 + (dy_q >> 1) + 32'(dy_q[0]) - 32'd1;
      off        = out_of_grid(xa_q) || out_of_grid(ya_q)
                 || out_of_grid(xb_q) || out_of_grid(yb_q);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH_E;
               i_d        = '0;
               sum_d      = '0;
               s1_d       = '0;
               max_d      = '0;
               over_d     = '0;
               err_d      = 1'b0;
               err_edge_d = '0;
               valid_d    = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_FETCH_E: begin
            if (i_q == 32'(N_EDGE)) begin
               state_d = S_FIN;
            end else begin
               re_e_d   = 1'b1;
               addr_e_d = i_q;
               state_d  = S_WAIT_E;
            end
         end
         S_WAIT_E: state_d = S_FETCH_A;
         S_FETCH_A: begin
            b_d      = dout_eb;
            re_p_d   = 1'b1;
            addr_p_d = dout_ea;
            state_d  = S_WAIT_A;
         end
         S_WAIT_A: state_d = S_FETCH_B;
         S_FETCH_B: begin
            xa_d     = dout_px;
            ya_d     = dout_py;
            re_p_d   = 1'b1;
            addr_p_d = b_q;
            state_d  = S_WAIT_B;
         end
         S_WAIT_B: state_d = S_LATCH_B;
         S_LATCH_B: begin
            xb_d    = dout_px;
            yb_d    = dout_py;
            state_d = S_ABS;
         end
         S_ABS: begin
            if (off) begin
               err_d      = 1'b1;
               err_edge_d = i_q;
               state_d    = S_FIN;
            end else begin
               dx_d    = ddx[31] ? -ddx : ddx;
               dy_d    = ddy[31] ? -ddy : ddy;
               d_d     = (ddx[31] ? -ddx : ddx) + (ddy[31] ? -ddy : ddy);
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            sum_d = sum_q + d_q - 32'sd1;
            s1_d  = s1_q + $signed(hop);
            if ($unsigned(d_q) > max_q) max_d = $unsigned(d_q);
            if (d_q > HOP_LIMIT) over_d = over_q + 32'd1;
            i_d     = i_q + 32'd1;
            state_d = S_FETCH_E;
         end
         S_FIN: begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         i_q        <= '0;
         b_q        <= '0;
         xa_q       <= '0;
         ya_q       <= '0;
         xb_q       <= '0;
         yb_q       <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         d_q        <= '0;
         re_e_q     <= 1'b0;
         re_p_q     <= 1'b0;
         addr_e_q   <= '0;
         addr_p_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_edge_q <= '0;
         sum_q      <= '0;
         s1_q       <= '0;
         max_q      <= '0;
         over_q     <= '0;
      end else begin
         i_q        <= i_d;
         b_q        <= b_d;
         xa_q       <= xa_d;
         ya_q       <= ya_d;
         xb_q       <= xb_d;
         yb_q       <= yb_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         d_q        <= d_d;
         re_e_q     <= re_e_d;
         re_p_q     <= re_p_d;
         addr_e_q   <= addr_e_d;
         addr_p_q   <= addr_p_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_edge_q <= err_edge_d;
         sum_q      <= sum_d;
         s1_q       <= s1_d;
         max_q      <= max_d;
         over_q     <= over_d;
      end
   end

   assign re_ea    = re_e_q;
   assign re_eb    = re_e_q;
   assign addr_ea  = addr_e_q;
   assign addr_eb  = addr_e_q;
   assign re_px    = re_p_q;
   assign re_py    = re_p_q;
   assign addr_px  = addr_p_q;
   assign addr_py  = addr_p_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign valid    = valid_q;
   assign err      = err_q;
   assign err_edge = err_edge_q;
   assign sum      = sum_q;
   assign sum_1hop = s1_q;
   assign max_dist = max_q;
   assign over_cnt = over_q;

endmodule

// File: tb/tb_placement_eval.sv
// Bench for placement_eval: three instances (30, 1 and 0 edges) sharing
// behavioural memories, checked against a golden model via a scoreboard.
module tb_placement_eval;

   localparam int GN  = 6;
   localparam int HOP = 2;

   typedef struct {
      int sum;
      int s1;
      int maxd;
      int over;
      int err;
      int eidx;
      int lat;
      int nfetch;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               start    [3];
   logic               re_ea    [3];
   logic               re_eb    [3];
   logic               re_px    [3];
   logic               re_py    [3];
   logic [31:0]        addr_ea  [3];
   logic [31:0]        addr_eb  [3];
   logic [31:0]        addr_px  [3];
   logic [31:0]        addr_py  [3];
   logic [31:0]        dout_ea  [3];
   logic [31:0]        dout_eb  [3];
   logic signed [31:0] dout_px  [3];
   logic signed [31:0] dout_py  [3];
   logic               busy     [3];
   logic               done     [3];
   logic               valid    [3];
   logic               err      [3];
   logic [31:0]        err_edge [3];
   logic signed [31:0] sum      [3];
   logic signed [31:0] sum_1hop [3];
   logic [31:0]        max_dist [3];
   logic [31:0]        over_cnt [3];

   int ea [32];
   int eb [32];
   int px [64];
   int py [64];

   int total = 0;
   int bad   = 0;
   exp_t exp_q [$];

   placement_eval #(.N_EDGE(30)) u0 (
      .clk(clk), .reset(reset), .start(start[0]),
      .re_ea(re_ea[0]), .re_eb(re_eb[0]),
      .addr_ea(addr_ea[0]), .addr_eb(addr_eb[0]),
      .dout_ea(dout_ea[0]), .dout_eb(dout_eb[0]),
      .re_px(re_px[0]), .re_py(re_py[0]),
      .addr_px(addr_px[0]), .addr_py(addr_py[0]),
      .dout_px(dout_px[0]), .dout_py(dout_py[0]),
      .busy(busy[0]), .done(done[0]), .valid(valid[0]), .err(err[0]),
      .err_edge(err_edge[0]), .sum(sum[0]), .sum_1hop(sum_1hop[0]),
      .max_dist(max_dist[0]), .over_cnt(over_cnt[0]));

   placement_eval #(.N_EDGE(1)) u1 (
      .clk(clk), .reset(reset), .start(start[1]),
      .re_ea(re_ea[1]), .re_eb(re_eb[1]),
      .addr_ea(addr_ea[1]), .addr_eb(addr_eb[1]),
      .dout_ea(dout_ea[1]), .dout_eb(dout_eb[1]),
      .re_px(re_px[1]), .re_py(re_py[1]),
      .addr_px(addr_px[1]), .addr_py(addr_py[1]),
      .dout_px(dout_px[1]), .dout_py(dout_py[1]),
      .busy(busy[1]), .done(done[1]), .valid(valid[1]), .err(err[1]),
      .err_edge(err_edge[1]), .sum(sum[1]), .sum_1hop(sum_1hop[1]),
      .max_dist(max_dist[1]), .over_cnt(over_cnt[1]));

   placement_eval #(.N_EDGE(0)) u2 (
      .clk(clk), .reset(reset), .start(start[2]),
      .re_ea(re_ea[2]), .re_eb(re_eb[2]),
      .addr_ea(addr_ea[2]), .addr_eb(addr_eb[2]),
      .dout_ea(dout_ea[2]), .dout_eb(dout_eb[2]),
      .re_px(re_px[2]), .re_py(re_py[2]),
      .addr_px(addr_px[2]), .addr_py(addr_py[2]),
      .dout_px(dout_px[2]), .dout_py(dout_py[2]),
      .busy(busy[2]), .done(done[2]), .valid(valid[2]), .err(err[2]),
      .err_edge(err_edge[2]), .sum(sum[2]), .sum_1hop(sum_1hop[2]),
      .max_dist(max_dist[2]), .over_cnt(over_cnt[2]));

   // Synchronous-read memories: data appears the cycle after the strobe
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (re_ea[k]) dout_ea[k] <= ea[addr_ea[k][4:0]];
         if (re_eb[k]) dout_eb[k] <= eb[addr_eb[k][4:0]];
         if (re_px[k]) dout_px[k] <= px[addr_px[k][5:0]];
         if (re_py[k]) dout_py[k] <= py[addr_py[k][5:0]];
      end
   end

   function automatic bit illegal(input int v);
      return (v < 0) || (v > GN - 1);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic exp_t golden(input int n);
      exp_t g;
      int dx, dy, d, a, b;
      g = '{default: 0};
      g.lat    = 9 * n + 3;
      g.nfetch = n;
      for (int e = 0; e < n; e++) begin
         a = ea[e];
         b = eb[e];
         if (illegal(px[a]) || illegal(py[a]) ||
             illegal(px[b]) || illegal(py[b])) begin
            g.err    = 1;
            g.eidx   = e;
            g.lat    = 9 * e + 10;
            g.nfetch = e + 1;
            break;
         end
         dx = iabs(px[a] - px[b]);
         dy = iabs(py[a] - py[b]);
         d  = dx + dy;
         g.sum += d - 1;
         g.s1  += (dx + 1) / 2 + (dy + 1) / 2 - 1;
         if (d > g.maxd) g.maxd = d;
         if (d > HOP) g.over++;
      end
      return g;
   endfunction

   task automatic run(input int k, input int n, input int poke);
      exp_t e;
      int c, nre, nrp;
      bit seen;
      exp_q.push_back(golden(n));
      @(negedge clk);
      start[k] = 1'b1;
      @(posedge clk);
      #1 start[k] = 1'b0;
      c = 1; seen = 0; nre = 0; nrp = 0;
      while (!seen && c < 2000) begin
         @(posedge clk);
         #1;
         c++;
         start[k] = (c == poke);
         if (re_ea[k]) nre++;
         if (re_px[k]) nrp++;
         if (done[k]) seen = 1;
      end
      start[k] = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (!seen || c != e.lat) begin
         bad++;
         $display("FAIL latency u%0d got=%0d want=%0d", k, c, e.lat);
      end
      total++;
      if (sum[k] !== e.sum) begin
         bad++;
         $display("FAIL sum u%0d got=%0d want=%0d", k, sum[k], e.sum);
      end
      total++;
      if (sum_1hop[k] !== e.s1) begin
         bad++;
         $display("FAIL sum_1hop u%0d got=%0d want=%0d", k, sum_1hop[k], e.s1);
      end
      total++;
      if (max_dist[k] !== e.maxd) begin
         bad++;
         $display("FAIL max_dist u%0d got=%0d want=%0d", k, max_dist[k], e.maxd);
      end
      total++;
      if (over_cnt[k] !== e.over) begin
         bad++;
         $display("FAIL over_cnt u%0d got=%0d want=%0d", k, over_cnt[k], e.over);
      end
      total++;
      if (err[k] !== e.err[0] || err_edge[k] !== e.eidx) begin
         bad++;
         $display("FAIL err u%0d got=%0d/%0d want=%0d/%0d",
                  k, err[k], err_edge[k], e.err, e.eidx);
      end
      total++;
      if (valid[k] !== 1'b1 || busy[k] !== 1'b0) begin
         bad++;
         $display("FAIL flags u%0d got=%b%b want=10", k, valid[k], busy[k]);
      end
      total++;
      if (nre != e.nfetch || nrp != 2 * e.nfetch) begin
         bad++;
         $display("FAIL reads u%0d got=%0d/%0d want=%0d/%0d",
                  k, nre, nrp, e.nfetch, 2 * e.nfetch);
      end
      @(posedge clk);
      #1;
      total++;
      if (done[k] !== 1'b0 || valid[k] !== 1'b1) begin
         bad++;
         $display("FAIL done_pulse u%0d got=%b%b want=01", k, done[k], valid[k]);
      end
   endtask

   task automatic fill_random();
      for (int j = 0; j < 64; j++) begin
         px[j] = $urandom_range(0, GN - 1);
         py[j] = $urandom_range(0, GN - 1);
      end
      for (int e = 0; e < 32; e++) begin
         ea[e] = $urandom_range(0, 35);
         eb[e] = $urandom_range(0, 35);
      end
      ea[1] = 2; eb[1] = 3;
      px[2] = 0; py[2] = 0; px[3] = GN - 1; py[3] = GN - 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({busy[k], done[k], valid[k], err[k], re_ea[k], re_px[k]} !== 6'b0
             || sum[k] !== 0 || max_dist[k] !== 0 || addr_ea[k] !== 0) begin
            bad++;
            $display("FAIL reset u%0d got=%b%b%b%b sum=%0d want=0",
                     k, busy[k], done[k], valid[k], err[k], sum[k]);
         end
      end
   endtask

   task automatic test_single_edge();
      ea[0] = 0; eb[0] = 1;
      px[0] = 0; py[0] = 0;
      px[1] = 0; py[1] = 1;
      run(1, 1, 0);
      px[1] = 3; py[1] = 4;
      run(1, 1, 0);
      total++;
      if (sum[1] !== 6 || sum_1hop[1] !== 3 || max_dist[1] !== 7
          || over_cnt[1] !== 1) begin
         bad++;
         $display("FAIL long_edge got=%0d/%0d/%0d/%0d want=6/3/7/1",
                  sum[1], sum_1hop[1], max_dist[1], over_cnt[1]);
      end
      px[1] = 1; py[1] = 1;
      run(1, 1, 0);
      px[1] = GN - 1; py[1] = GN - 1;
      run(1, 1, 0);
      px[1] = GN; py[1] = 0;
      run(1, 1, 0);
   endtask

   task automatic test_empty();
      run(2, 0, 0);
   endtask

   task automatic test_full_grid();
      fill_random();
      run(0, 30, 0);
      run(0, 30, 5);
   endtask

   task automatic test_unplaced();
      int keep;
      keep = eb[2];
      eb[2] = 40;
      px[40] = -1; py[40] = -1;
      run(0, 30, 0);
      eb[2] = keep;
      run(0, 30, 0);
   endtask

   task automatic test_reset_mid_run();
      bit stray;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      total++;
      if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || sum[0] !== 0
          || over_cnt[0] !== 0 || re_px[0] !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got=%b%b sum=%0d want=00 sum=0",
                  busy[0], valid[0], sum[0]);
      end
      stray = 0;
      repeat (300) begin
         @(posedge clk);
         #1 if (done[0]) stray = 1;
      end
      total++;
      if (stray) begin
         bad++;
         $display("FAIL mid_reset_done got=1 want=0");
      end
      run(0, 30, 0);
   endtask

   task automatic test_back_to_back();
      int first, second, c;
      bit vlow;
      exp_t e;
      px[0] = 0; py[0] = 0; px[1] = 2; py[1] = 1;
      ea[0] = 0; eb[0] = 1;
      exp_q.push_back(golden(1));
      @(negedge clk);
      start[1] = 1'b1;
      @(posedge clk);
      first = 0; second = 0; vlow = 0;
      for (c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (c == 23) start[1] = 1'b0;
         if (done[1] && first == 0) first = c + 1;
         else if (done[1]) second = c + 1;
         if (c + 1 == 13) vlow = (valid[1] === 1'b0);
      end
      e = exp_q.pop_front();
      total++;
      if (first != 12 || second != 24) begin
         bad++;
         $display("FAIL held_start got=%0d,%0d want=12,24", first, second);
      end
      total++;
      if (!vlow) begin
         bad++;
         $display("FAIL held_valid got=1 want=0");
      end
      total++;
      if (sum[1] !== e.sum || max_dist[1] !== e.maxd) begin
         bad++;
         $display("FAIL held_result got=%0d/%0d want=%0d/%0d",
                  sum[1], max_dist[1], e.sum, e.maxd);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) start[k] = 1'b0;
      reset = 1'b1;
      test_reset();
      test_single_edge();
      test_empty();
      test_full_grid();
      test_unplaced();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/placement_eval.md
PLACEMENT_EVAL -- requirements
Module: placement_eval

Interface
REQ-001 Parameter N_EDGE, default 30: number of edges in the edge-list memories.
REQ-002 Parameter N, default 6: grid side; legal coordinates are 0..N-1.
REQ-003 Parameter HOP_LIMIT, default 2: Manhattan distance above which an edge is counted as over-limit.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  begin evaluation; sampled only in IDLE
- re_ea, re_eb  out  1  edge-memory read strobes, source and sink
- addr_ea, addr_eb  out  32  edge index
- dout_ea, dout_eb  in  32  node id
- re_px, re_py  out  1  position-memory read strobes
- addr_px, addr_py  out  32  node id
- dout_px, dout_py  in  32 signed  node X / Y coordinate
- busy  out  1  evaluation in progress
- done  out  1  one-cycle completion pulse
- valid  out  1  results held and complete; level
- err  out  1  illegal position found
- err_edge  out  32  index of the failing edge
- sum  out  32 signed  sum of (d-1)
- sum_1hop  out  32 signed  1-hop cost
- max_dist  out  32  largest d
- over_cnt  out  32  edges with d > HOP_LIMIT
REQ-005 Clock is clk; reset is synchronous and active-high. The polarity and synchronicity are fixed.

Function
REQ-006 All outputs shall be registered.
REQ-007 Each re_* shall be high for exactly one cycle, with addr_* valid in the same cycle; the memory returns dout_* in the following cycle, and the block shall sample it then.
REQ-008 FSM states and transitions:
- IDLE -> FETCH_E on start.
- FETCH_E -> WAIT_E -> FETCH_A -> WAIT_A -> FETCH_B -> WAIT_B -> LATCH_B -> ABS -> ACC -> FETCH_E.
- FETCH_E -> FIN when i == N_EDGE.
- FIN -> IDLE.
REQ-009 On leaving IDLE on start, the block shall:
- clear i, sum, sum_1hop, max_dist, over_cnt, err, err_edge and valid;
- set busy = 1.
REQ-010 FETCH_E shall issue re_ea/re_eb at address i.
REQ-011 FETCH_A shall latch node ids a and b, and issue re_px/re_py at address a.
REQ-012 FETCH_B shall latch xa and ya, and issue re_px/re_py at address b.
REQ-013 LATCH_B shall latch xb and yb.
REQ-014 ABS shall compute dx = |xa-xb| and dy = |ya-yb| as 32-bit signed magnitudes, and d = dx + dy.
REQ-015 ABS range check: if any of xa, ya, xb, yb is < 0 or >= N (this includes the unplaced marker -1), the block shall:
- set err = 1 and err_edge = i;
- not accumulate that edge;
- go to FIN.
REQ-016 ACC shall update the results as follows:
- sum += d - 1;
- sum_1hop += ((dx>>1) + dx[0]) + ((dy>>1) + dy[0]) - 1;
- max_dist = max(max_dist, d);
- over_cnt += 1 if d > HOP_LIMIT;
- i += 1.
REQ-017 Accumulation shall be 32-bit two's complement and wrap silently; no saturation.
REQ-018 FIN shall set busy = 0, valid = 1 and done = 1; done shall drop after one cycle.
REQ-019 Results shall hold until the next accepted start or reset.
REQ-020 Latency: done shall be high in cycle 9*N_EDGE + 3 counted from the start-sample cycle. With no error, each edge takes exactly 9 cycles.
REQ-021 N_EDGE = 0: done shall arrive in cycle 3, with all results zero and valid = 1.
REQ-022 start while busy shall be ignored.
REQ-023 start held high across FIN shall begin a new run in the IDLE cycle that follows FIN.
REQ-024 If start and done coincide, the new run shall clear valid on the next cycle.
REQ-025 The block shall never issue a write; the memories are read-only to this block.

Reset
REQ-026 On reset, the block shall:
- go to IDLE;
- drive all re_* = 0 and all addr_* = 0;
- clear busy, done, valid, err, err_edge, sum, sum_1hop, max_dist, over_cnt and i.
REQ-027 Reset mid-run shall abandon the run with no done pulse; the next start shall give results identical to an uninterrupted run.

Verification
REQ-028 Adjacent edge: N_EDGE=1, A(0,0), B(0,1) -> sum=0, sum_1hop=0, max_dist=1, over_cnt=0, err=0, done in cycle 12.
REQ-029 Long edge: N_EDGE=1, A(0,0), B(3,4), HOP_LIMIT=2 -> sum=6, sum_1hop=3, max_dist=7, over_cnt=1.
REQ-030 Unplaced node: N_EDGE=4, sink of edge 2 at (-1,-1) -> err=1, err_edge=2, sums cover edges 0-1 only, valid=1, single done pulse.
REQ-031 Empty list: N_EDGE=0 -> done in cycle 3, all results 0, no re_* pulse.
REQ-032 Start while busy: pulse start at cycle 5 of a running evaluation -> ignored, and results and timing are unchanged.
REQ-033 Reset mid-run: reset at cycle 20, then start -> done in cycle 9*N_EDGE+3 after the new start, and results equal the golden model (e.g. the 6x6 grid with 30 edges).
